datapath_control_unit: RTL and testbench

Hard-wired Moore controller that sequences the Phase-1 Datapath through instruction fetch (T0-T2) and register-register ALU execute (T3-T6). It replaces the hand-written testbench state sequencing. It decodes IR fields and drives the one-hot register-file selects. Its single-cycle control outputs connect directly to the existing Datapath enable and out pins.

---
 rtl/datapath_control_unit_if.sv | 42 ++++
 rtl/datapath_control_unit.sv | 154 +++++++++++++++
 tb/tb_datapath_control_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_control_unit_if.sv
// Control bundle between the sequencer and the Phase-1 Datapath.
// The Datapath side drives run/ir. The controller drives the enables, out pins and selects.
interface datapath_control_unit_if #(
    parameter int NREG = 16,
    parameter int OPW  = 5
);
    logic            run;
    logic [31:0]     ir;
    logic            pc_out;
    logic            mdr_out;
    logic            zlo_out;
    logic            zhi_out;
    logic            mar_enable;
    logic            mdr_enable;
    logic            ir_enable;
    logic            y_enable;
    logic            z_enable;
    logic            pc_increment;
    logic            read;
    logic            lo_enable;
    logic            hi_enable;
    logic [OPW-1:0]  op_code;
    logic [NREG-1:0] reg_out_sel;
    logic [NREG-1:0] reg_in_sel;
    logic            instr_done;
    logic            halted;
    logic [3:0]      state_dbg;

    modport master (
        output run, ir,
        input  pc_out, mdr_out, zlo_out, zhi_out, mar_enable, mdr_enable, ir_enable,
               y_enable, z_enable, pc_increment, read, lo_enable, hi_enable, op_code,
               reg_out_sel, reg_in_sel, instr_done, halted, state_dbg
    );

    modport slave (
        input  run, ir,
        output pc_out, mdr_out, zlo_out, zhi_out, mar_enable, mdr_enable, ir_enable,
               y_enable, z_enable, pc_increment, read, lo_enable, hi_enable, op_code,
               reg_out_sel, reg_in_sel, instr_done, halted, state_dbg
    );
endinterface

// File: rtl/datapath_control_unit.sv
// Hard-wired Moore sequencer: fetch (T0-T2), then register-register ALU execute (T3-T6).
//  state | meaning
//  IDLE  | waiting for run, all outputs low
//  T0-T2 | fetch: PC->MAR, memory->MDR, MDR->IR
//  T3-T6 | execute, length depends on the opcode class
//  HALT  | illegal opcode seen, sticky until clr
module datapath_control_unit #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic clk,
    input  logic clr,
    datapath_control_unit_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
    } state_t;

    state_t         state, state_nxt;
    logic [OPW-1:0] opc_q;
    logic [3:0]     ra_q, rb_q, rc_q;
    logic           legal, unary, muldiv;
    logic           unused_ir;

    assign unused_ir     = ^bus.ir[14:0];
    assign bus.state_dbg = state;

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        return NREG'(1) << idx;
    endfunction

    always_comb begin
        legal  = 1'b0;
        unary  = 1'b0;
        muldiv = 1'b0;
        case (opc_q)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: legal = 1'b1;
            5'b01111, 5'b10000: begin legal = 1'b1; muldiv = 1'b1; end
            5'b10001, 5'b10010: begin legal = 1'b1; unary  = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IR fields are frozen at the end of fetch so the Datapath may reload IR during execute.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            opc_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
        end else if (state == T2) begin
            opc_q <= bus.ir[31:32-OPW];
            ra_q  <= bus.ir[26:23];
            rb_q  <= bus.ir[22:19];
            rc_q  <= bus.ir[18:15];
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.pc_out       = 1'b0;
        bus.mdr_out      = 1'b0;
        bus.zlo_out      = 1'b0;
        bus.zhi_out      = 1'b0;
        bus.mar_enable   = 1'b0;
        bus.mdr_enable   = 1'b0;
        bus.ir_enable    = 1'b0;
        bus.y_enable     = 1'b0;
        bus.z_enable     = 1'b0;
        bus.pc_increment = 1'b0;
        bus.read         = 1'b0;
        bus.lo_enable    = 1'b0;
        bus.hi_enable    = 1'b0;
        bus.op_code      = '0;
        bus.reg_out_sel  = '0;
        bus.reg_in_sel   = '0;
        bus.instr_done   = 1'b0;
        bus.halted       = 1'b0;
        case (state)
            IDLE: if (bus.run) state_nxt = T0;
            T0: begin
                bus.pc_out       = 1'b1;
                bus.mar_enable   = 1'b1;
                bus.pc_increment = 1'b1;
                state_nxt        = T1;
            end
            T1: begin
                bus.read       = 1'b1;
                bus.mdr_enable = 1'b1;
                state_nxt      = T2;
            end
            T2: begin
                bus.mdr_out   = 1'b1;
                bus.ir_enable = 1'b1;
                state_nxt     = T3;
            end
            T3: begin
                if (!legal) begin
                    state_nxt = HALT;
                end else begin
                    bus.op_code     = opc_q;
                    bus.reg_out_sel = onehot(rb_q);
                    bus.z_enable    = unary;
                    bus.y_enable    = !unary;
                    state_nxt       = T4;
                end
            end
            T4: begin
                bus.op_code = opc_q;
                if (unary) begin
                    bus.zlo_out    = 1'b1;
                    bus.reg_in_sel = onehot(ra_q);
                    bus.instr_done = 1'b1;
                    state_nxt      = bus.run ? T0 : IDLE;
                end else begin
                    bus.reg_out_sel = onehot(rc_q);
                    bus.z_enable    = 1'b1;
                    state_nxt       = T5;
                end
            end
            T5: begin
                bus.op_code = opc_q;
                bus.zlo_out = 1'b1;
                if (muldiv) begin
                    bus.lo_enable = 1'b1;
                    state_nxt     = T6;
                end else begin
                    bus.reg_in_sel = onehot(ra_q);
                    bus.instr_done = 1'b1;
                    state_nxt      = bus.run ? T0 : IDLE;
                end
            end
            T6: begin
                bus.op_code    = opc_q;
                bus.zhi_out    = 1'b1;
                bus.hi_enable  = 1'b1;
                bus.instr_done = 1'b1;
                state_nxt      = bus.run ? T0 : IDLE;
            end
            HALT: bus.halted = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_datapath_control_unit.sv
// Self-checking bench for datapath_control_unit: table vectors, corner sequences, random instruction streams.
module tb_datapath_control_unit;
    typedef struct packed {
        logic pc_out, mdr_out, zlo_out, zhi_out, mar_enable, mdr_enable, ir_enable;
        logic y_enable, z_enable, pc_increment, read, lo_enable, hi_enable;
        logic [4:0]  op_code;
        logic [15:0] reg_out_sel;
        logic [15:0] reg_in_sel;
        logic        instr_done, halted;
        logic [3:0]  state_dbg;
    } snap_t;

    typedef struct {
        logic [31:0] ir;
        int          len;
        logic [15:0] t3_sel;
        logic [15:0] t4_sel;
        logic [15:0] in_sel;
    } vec_t;

    localparam logic [31:0] IR_AND = 32'h2A1B8000;
    localparam logic [31:0] IR_ADD1 = 32'h18788000;
    localparam logic [31:0] IR_ADD2 = 32'h191A0000;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    datapath_control_unit_if #(.NREG(16), .OPW(5)) bus ();
    datapath_control_unit #(.NREG(16), .OPW(5)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    function automatic snap_t sample();
        snap_t s;
        s.pc_out = bus.pc_out;           s.mdr_out = bus.mdr_out;
        s.zlo_out = bus.zlo_out;         s.zhi_out = bus.zhi_out;
        s.mar_enable = bus.mar_enable;   s.mdr_enable = bus.mdr_enable;
        s.ir_enable = bus.ir_enable;     s.y_enable = bus.y_enable;
        s.z_enable = bus.z_enable;       s.pc_increment = bus.pc_increment;
        s.read = bus.read;               s.lo_enable = bus.lo_enable;
        s.hi_enable = bus.hi_enable;     s.op_code = bus.op_code;
        s.reg_out_sel = bus.reg_out_sel; s.reg_in_sel = bus.reg_in_sel;
        s.instr_done = bus.instr_done;   s.halted = bus.halted;
        s.state_dbg = bus.state_dbg;
        return s;
    endfunction

    // 0 illegal, 1 two-operand ALU, 2 mul/div, 3 neg/not
    function automatic int cls_of(logic [4:0] opc);
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return 1;
            5'd15, 5'd16: return 2;
            5'd17, 5'd18: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int len_of(logic [31:0] instr);
        case (cls_of(instr[31:27]))
            1: return 6;
            2: return 7;
            3: return 5;
            default: return 4;
        endcase
    endfunction

    // Expected outputs for phase p (0 = T0) of an instruction, from its micro-op list.
    function automatic snap_t model(logic [31:0] instr, int p);
        snap_t s;
        int c;
        logic [15:0] ra_bit, rb_bit, rc_bit;
        s = '0;
        c = cls_of(instr[31:27]);
        ra_bit = 16'h1 << instr[26:23];
        rb_bit = 16'h1 << instr[22:19];
        rc_bit = 16'h1 << instr[18:15];
        s.state_dbg = 4'(p + 1);
        if (p == 0) begin
            s.pc_out = 1; s.mar_enable = 1; s.pc_increment = 1;
        end else if (p == 1) begin
            s.read = 1; s.mdr_enable = 1;
        end else if (p == 2) begin
            s.mdr_out = 1; s.ir_enable = 1;
        end else if (c != 0) begin
            s.op_code = instr[31:27];
            if (c == 3) begin
                if (p == 3) begin s.reg_out_sel = rb_bit; s.z_enable = 1; end
                else begin s.zlo_out = 1; s.reg_in_sel = ra_bit; s.instr_done = 1; end
            end else if (p == 3) begin
                s.reg_out_sel = rb_bit; s.y_enable = 1;
            end else if (p == 4) begin
                s.reg_out_sel = rc_bit; s.z_enable = 1;
            end else if (p == 5) begin
                s.zlo_out = 1;
                if (c == 1) begin s.reg_in_sel = ra_bit; s.instr_done = 1; end
                else s.lo_enable = 1;
            end else begin
                s.zhi_out = 1; s.hi_enable = 1; s.instr_done = 1;
            end
        end
        return s;
    endfunction

    function automatic snap_t halt_snap();
        snap_t s;
        s = '0;
        s.halted = 1'b1;
        s.state_dbg = 4'd8;
        return s;
    endfunction

    task automatic chk(input string nm, input snap_t exp);
        snap_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller leaves the DUT one edge away from T0; first sample lands in T0.
    task automatic do_instr(input logic [31:0] instr, input logic [31:0] next_ir,
                            input bit keep_run, input bit drop_mid, output int o_len,
                            output logic [15:0] o_t3, output logic [15:0] o_t4,
                            output logic [15:0] o_in);
        int n;
        snap_t a;
        n = len_of(instr);
        o_len = 0; o_t3 = '0; o_t4 = '0; o_in = '0;
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            a = sample();
            chk($sformatf("ir%08h_p%0d", instr, p), model(instr, p));
            if (a.instr_done) o_len = p + 1;
            if (p == 3) o_t3 = a.reg_out_sel;
            if (p == 4) o_t4 = a.reg_out_sel;
            o_in = o_in | a.reg_in_sel;
            if (p == 3) bus.ir = next_ir;
            if (drop_mid && p == 4) bus.run = 1'b0;
            if (p == n - 1 && !keep_run) bus.run = 1'b0;
        end
    endtask

    task automatic clr_pulse(input string nm);
        clr = 1'b0;
        #1;
        chk(nm, '0);
        bus.run = 1'b0;
        #1;
        clr = 1'b1;
        @(negedge clk);
        chk({nm, "_after"}, '0);
    endtask

    vec_t        tbl[7];
    logic [4:0]  legal_ops[13];
    logic [31:0] irs[4];
    int          ol;
    int          cnt;
    logic [15:0] o3, o4, oi;

    initial begin
        tbl[0] = '{IR_AND,       6, 16'h0008, 16'h0080, 16'h0010};
        tbl[1] = '{32'h81180000, 7, 16'h0008, 16'h0001, 16'h0000};
        tbl[2] = '{32'h92180000, 5, 16'h0008, 16'h0000, 16'h0010};
        tbl[3] = '{IR_ADD1,      6, 16'h8000, 16'h0002, 16'h0001};
        tbl[4] = '{32'h7A948000, 7, 16'h0004, 16'h0200, 16'h0000};
        tbl[5] = '{32'h8FF00000, 5, 16'h4000, 16'h0000, 16'h8000};
        tbl[6] = '{32'h50B60000, 6, 16'h0040, 16'h1000, 16'h0002};
        legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                      5'd15, 5'd16, 5'd17, 5'd18};

        bus.run = 1'b0;
        bus.ir  = '0;
        #12;
        chk("reset_idle", '0);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_hold", '0);
        end

        // table vectors, back to back; IR reloaded right after each latch
        bus.ir  = tbl[0].ir;
        bus.run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_instr(tbl[i].ir, (i < 6) ? tbl[i+1].ir : $urandom(), i < 6, 1'b0, ol, o3, o4, oi);
            chk_val($sformatf("tbl%0d_len", i), ol, tbl[i].len);
            chk_val($sformatf("tbl%0d_t3sel", i), int'(o3), int'(tbl[i].t3_sel));
            chk_val($sformatf("tbl%0d_t4sel", i), int'(o4), int'(tbl[i].t4_sel));
            chk_val($sformatf("tbl%0d_insel", i), int'(oi), int'(tbl[i].in_sel));
        end
        @(negedge clk);
        chk("table_end_idle", '0);

        // asynchronous clear in T4 of an and
        bus.ir  = IR_AND;
        bus.run = 1'b1;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            chk($sformatf("and_pre_clr_p%0d", p), model(IR_AND, p));
        end
        #2;
        clr = 1'b0;
        #1;
        chk("async_clr_mid_t4", '0);
        bus.run = 1'b0;
        #1;
        clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_clr", '0);
        end

        // illegal opcode: sticky halt with run held high
        bus.ir  = 32'h00000000;
        bus.run = 1'b1;
        do_instr(32'h00000000, 32'h18788000, 1'b1, 1'b0, ol, o3, o4, oi);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("halt_hold%0d", k), halt_snap());
        end
        clr_pulse("halt_clr");

        // two adds back to back, run dropped in T4 of the second
        bus.ir  = IR_ADD1;
        bus.run = 1'b1;
        do_instr(IR_ADD1, IR_ADD2, 1'b1, 1'b0, ol, o3, o4, oi);
        do_instr(IR_ADD2, 32'h0, 1'b1, 1'b1, ol, o3, o4, oi);
        chk_val("add2_done_phase", ol, 6);
        @(negedge clk);
        chk("run_drop_idle", '0);

        // random instruction streams
        for (int t = 0; t < 30; t++) begin
            cnt = $urandom_range(1, 4);
            for (int j = 0; j < 4; j++) begin
                irs[j] = $urandom();
                if ($urandom_range(0, 4) != 0)
                    irs[j][31:27] = legal_ops[$urandom_range(0, 12)];
            end
            bus.ir  = irs[0];
            bus.run = 1'b1;
            for (int j = 0; j < cnt; j++) begin
                if (cls_of(irs[j][31:27]) == 0) begin
                    do_instr(irs[j], $urandom(), 1'b1, 1'b0, ol, o3, o4, oi);
                    repeat (2) begin
                        @(negedge clk);
                        chk("rand_halt", halt_snap());
                    end
                    clr_pulse("rand_halt_clr");
                    break;
                end
                do_instr(irs[j], (j < 3) ? irs[j+1] : $urandom(), j < cnt - 1, 1'b0, ol, o3, o4, oi);
                if (j == cnt - 1) begin
                    @(negedge clk);
                    chk("rand_end_idle", '0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
